// File: rtl/hu_rr_selector.sv
`default_nettype none
// ============================================================================
// Module   : hu_rr_selector
// Purpose  : N-channel round-robin selector feeding one registered output
//            stage. In packet mode the grant stays on one channel until that
//            channel's last beat has been transferred.
// Revision : 1.0  initial release
// ============================================================================
module hu_rr_selector #(
  parameter int  channels = 4,
  parameter type seltype  = logic [7:0],
  parameter bit  packet   = 1'b0,
  localparam int cw       = (channels > 1) ? $clog2(channels) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [channels-1:0] d_valid,
  output logic [channels-1:0] d_ready,
  input  logic [channels-1:0] d_last,
  input  seltype              d [channels],
  output logic                q_valid,
  input  logic                q_ready,
  output seltype              q,
  output logic                q_last,
  output logic [cw-1:0]       q_chan
);

  // Channel count as a cw+1 bit value, so the wrap compare never overflows.
  localparam logic [cw:0] c_nch = (cw+1)'(channels);

  // Registered state
  logic          q_valid_q,   q_valid_d;
  seltype        q_q,         q_d;
  logic          q_last_q,    q_last_d;
  logic [cw-1:0] q_chan_q,    q_chan_d;
  logic [cw-1:0] ptr_q,       ptr_d;
  logic          lock_q,      lock_d;
  logic [cw-1:0] lock_chan_q, lock_chan_d;

  // Combinational arbitration results
  logic                load;
  logic [channels-1:0] cand;
  logic                found;
  logic [cw-1:0]       gnt;
  logic                xfer;

  // The output stage can take a beat when it is empty or being drained.
  assign load = !q_valid_q || q_ready;

  // Candidate set: only the locked channel while a packet is in flight.
  always_comb begin
    cand = d_valid;
    if (packet && lock_q) begin
      cand = '0;
      cand[lock_chan_q] = d_valid[lock_chan_q];
    end
  end

  // Round-robin scan starting at ptr, wrapping past the last channel.
  always_comb begin
    logic [cw:0] sum;
    found = 1'b0;
    gnt   = '0;
    sum   = '0;
    for (int i = 0; i < channels; i++) begin
      sum = {1'b0, ptr_q} + (cw+1)'(i);
      if (sum >= c_nch) sum = sum - c_nch;
      if (!found && cand[sum[cw-1:0]]) begin
        found = 1'b1;
        gnt   = sum[cw-1:0];
      end
    end
  end

  assign xfer = load && found;

  // One-hot ready for the granted channel only.
  always_comb begin
    d_ready = '0;
    if (xfer) d_ready[gnt] = 1'b1;
  end

  // Next state of the output stage, pointer and packet lock.
  always_comb begin
    logic [cw:0] nxt;
    q_valid_d   = q_valid_q;
    q_d         = q_q;
    q_last_d    = q_last_q;
    q_chan_d    = q_chan_q;
    ptr_d       = ptr_q;
    lock_d      = lock_q;
    lock_chan_d = lock_chan_q;
    nxt         = {1'b0, gnt} + (cw+1)'(1);
    if (nxt >= c_nch) nxt = '0;

    if (load) q_valid_d = found;

    if (xfer) begin
      q_d      = d[gnt];
      q_last_d = d_last[gnt];
      q_chan_d = gnt;
      if (!packet) begin
        ptr_d = nxt[cw-1:0];
      end else if (d_last[gnt]) begin
        ptr_d  = nxt[cw-1:0];
        lock_d = 1'b0;
      end else begin
        lock_d      = 1'b1;
        lock_chan_d = gnt;
      end
    end

    // Without packet mode there is no lock state at all.
    if (!packet) begin
      lock_d      = 1'b0;
      lock_chan_d = '0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_valid_q   <= 1'b0;
      q_q         <= '0;
      q_last_q    <= 1'b0;
      q_chan_q    <= '0;
      ptr_q       <= '0;
      lock_q      <= 1'b0;
      lock_chan_q <= '0;
    end else begin
      q_valid_q   <= q_valid_d;
      q_q         <= q_d;
      q_last_q    <= q_last_d;
      q_chan_q    <= q_chan_d;
      ptr_q       <= ptr_d;
      lock_q      <= lock_d;
      lock_chan_q <= lock_chan_d;
    end
  end

  assign q_valid = q_valid_q;
  assign q       = q_q;
  assign q_last  = q_last_q;
  assign q_chan  = q_chan_q;

endmodule
`default_nettype wire

// File: tb/tb_hu_rr_selector.sv
`default_nettype none
// ============================================================================
// Module   : tb_hu_rr_selector
// Purpose  : Directed bench for hu_rr_selector; one instance in beat mode,
//            one in packet mode, sharing clock and reset.
// Revision : 1.0  initial release
// ============================================================================
module tb_hu_rr_selector;

  logic clk;
  logic rst_n;

  // Beat-mode instance signals
  logic [3:0] dv0, dr0, dl0;
  logic [7:0] d0 [4];
  logic       qv0, qr0, ql0;
  logic [7:0] q0;
  logic [1:0] qc0;

  // Packet-mode instance signals
  logic [3:0] dv1, dr1, dl1;
  logic [7:0] d1 [4];
  logic       qv1, qr1, ql1;
  logic [7:0] q1;
  logic [1:0] qc1;

  int checks = 0;
  int errors = 0;

  hu_rr_selector #(.channels(4), .seltype(logic [7:0]), .packet(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .d_valid(dv0), .d_ready(dr0), .d_last(dl0), .d(d0),
    .q_valid(qv0), .q_ready(qr0), .q(q0), .q_last(ql0), .q_chan(qc0)
  );

  hu_rr_selector #(.channels(4), .seltype(logic [7:0]), .packet(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .d_valid(dv1), .d_ready(dr1), .d_last(dl1), .d(d1),
    .q_valid(qv1), .q_ready(qr1), .q(q1), .q_last(ql1), .q_chan(qc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    dv0 = '0; dl0 = '0; qr0 = 1'b0;
    dv1 = '0; dl1 = '0; qr1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d0[i] = 8'h00;
      d1[i] = 8'h00;
    end

    // ---- Reset state ----
    #12;
    chk("rst_qv0", 32'(qv0), 32'd0);
    chk("rst_q0", 32'(q0), 32'h00);
    chk("rst_qc0", 32'(qc0), 32'd0);
    chk("rst_ql0", 32'(ql0), 32'd0);
    chk("rst_qv1", 32'(qv1), 32'd0);
    rst_n = 1'b1;
    tick;
    chk("idle_qv0", 32'(qv0), 32'd0);
    chk("idle_dr0", 32'(dr0), 32'h0);
    chk("idle_qc0", 32'(qc0), 32'd0);

    // ---- Beat mode: all channels valid, rotating grant ----
    for (int i = 0; i < 4; i++) d0[i] = 8'h10 + 8'(i);
    dv0 = 4'b1111;
    qr0 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rr_dr", 32'(dr0), 32'(4'b0001 << (k % 4)));
      tick;
      chk("rr_qv", 32'(qv0), 32'd1);
      chk("rr_qc", 32'(qc0), 32'(k % 4));
      chk("rr_q", 32'(q0), 32'h10 + 32'(k % 4));
    end

    // ---- Asynchronous reset in the middle of traffic ----
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_qv", 32'(qv0), 32'd0);
    chk("arst_qc", 32'(qc0), 32'd0);
    chk("arst_q", 32'(q0), 32'h00);
    dv0 = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick;

    // ---- Stall: only ch2 valid, consumer not ready ----
    d0[2] = 8'hA5;
    dv0 = 4'b0100;
    qr0 = 1'b0;
    #1;
    chk("stall_dr_first", 32'(dr0), 32'b0100);
    tick;
    chk("stall_qv_load", 32'(qv0), 32'd1);
    chk("stall_q_load", 32'(q0), 32'hA5);
    chk("stall_qc_load", 32'(qc0), 32'd2);
    repeat (3) begin
      #1;
      chk("stall_dr", 32'(dr0), 32'h0);
      tick;
      chk("stall_qv", 32'(qv0), 32'd1);
      chk("stall_q", 32'(q0), 32'hA5);
      chk("stall_qc", 32'(qc0), 32'd2);
    end
    qr0 = 1'b1;
    #1;
    chk("unstall_dr", 32'(dr0), 32'b0100);
    tick;
    chk("unstall_qv", 32'(qv0), 32'd1);
    chk("unstall_qc", 32'(qc0), 32'd2);
    dv0 = '0;
    #1;
    chk("drain_dr", 32'(dr0), 32'h0);
    tick;
    chk("drain_qv", 32'(qv0), 32'd0);

    // ---- Pointer wrap: ptr is 3, ch0 and ch3 valid ----
    dv0 = 4'b1001;
    #1;
    chk("wrap_dr3", 32'(dr0), 32'b1000);
    tick;
    chk("wrap_qc3", 32'(qc0), 32'd3);
    chk("wrap_q3", 32'(q0), 32'h13);
    #1;
    chk("wrap_dr0", 32'(dr0), 32'b0001);
    tick;
    chk("wrap_qc0", 32'(qc0), 32'd0);
    chk("wrap_q0", 32'(q0), 32'h10);
    dv0 = '0;

    // ---- Packet mode: single-beat packet on ch0 moves ptr to 1 ----
    d1[0] = 8'h40;
    d1[3] = 8'h43;
    dv1 = 4'b0001;
    dl1 = 4'b0001;
    #1;
    chk("pk_pre_dr", 32'(dr1), 32'b0001);
    tick;
    chk("pk_pre_qc", 32'(qc1), 32'd0);
    chk("pk_pre_ql", 32'(ql1), 32'd1);

    // ---- Packet mode: 3-beat packet on ch1 with ch0/ch3 contending ----
    dv1 = 4'b1011;
    dl1 = 4'b1001;
    d1[1] = 8'h31;
    #1;
    chk("pk_b1_dr", 32'(dr1), 32'b0010);
    tick;
    chk("pk_b1_qc", 32'(qc1), 32'd1);
    chk("pk_b1_q", 32'(q1), 32'h31);
    chk("pk_b1_ql", 32'(ql1), 32'd0);
    d1[1] = 8'h32;
    #1;
    chk("pk_b2_dr", 32'(dr1), 32'b0010);
    tick;
    chk("pk_b2_qc", 32'(qc1), 32'd1);
    chk("pk_b2_q", 32'(q1), 32'h32);
    d1[1] = 8'h33;
    dl1 = 4'b1011;
    #1;
    chk("pk_b3_dr", 32'(dr1), 32'b0010);
    tick;
    chk("pk_b3_qc", 32'(qc1), 32'd1);
    chk("pk_b3_q", 32'(q1), 32'h33);
    chk("pk_b3_ql", 32'(ql1), 32'd1);
    dv1 = 4'b1001;
    #1;
    chk("pk_next_dr", 32'(dr1), 32'b1000);
    tick;
    chk("pk_next_qc", 32'(qc1), 32'd3);
    chk("pk_next_q", 32'(q1), 32'h43);
    #1;
    chk("pk_then_dr", 32'(dr1), 32'b0001);
    tick;
    chk("pk_then_qc", 32'(qc1), 32'd0);
    chk("pk_then_q", 32'(q1), 32'h40);

    // ---- Packet mode: locked channel goes idle -> bubbles ----
    dv1 = 4'b0011;
    dl1 = 4'b0001;
    d1[1] = 8'h51;
    #1;
    chk("bub_start_dr", 32'(dr1), 32'b0010);
    tick;
    chk("bub_start_qc", 32'(qc1), 32'd1);
    chk("bub_start_q", 32'(q1), 32'h51);
    dv1 = 4'b0001;
    repeat (2) begin
      #1;
      chk("bub_dr", 32'(dr1), 32'h0);
      tick;
      chk("bub_qv", 32'(qv1), 32'd0);
    end
    dv1 = 4'b0011;
    dl1 = 4'b0011;
    d1[1] = 8'h52;
    #1;
    chk("bub_end_dr", 32'(dr1), 32'b0010);
    tick;
    chk("bub_end_qc", 32'(qc1), 32'd1);
    chk("bub_end_q", 32'(q1), 32'h52);
    chk("bub_end_ql", 32'(ql1), 32'd1);
    dv1 = 4'b0001;
    #1;
    chk("bub_after_dr", 32'(dr1), 32'b0001);
    tick;
    chk("bub_after_qv", 32'(qv1), 32'd1);
    chk("bub_after_qc", 32'(qc1), 32'd0);
    dv1 = '0;
    tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
